// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit adder/subtractor for the y86 ALU path.
//
// Adds CHUNK bits per clock, starting with the least significant chunk. The
// carry between chunks is held in a flop, so the combinational path is only
// CHUNK bits long. An operation takes NCHUNK = WIDTH/CHUNK cycles in RUN.
// Subtraction is a + ~b + 1, with the +1 supplied as the initial carry.
//
// Optional build macro: SEQ_CHUNK_ADDER_ABORT_EN adds the abort input.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request; accepted only while busy=0
//   sub    in   0 = a+b, 1 = a-b (sampled with start)
//   a, b   in   WIDTH-bit operands (sampled with start)
//   abort  in   (SEQ_CHUNK_ADDER_ABORT_EN only) cancel the running operation
//   busy   out  high while chunks are being processed
//   done   out  one-cycle pulse when a result is published
//   sum    out  WIDTH-bit result, held until the next completion
//   cout   out  carry out of the MSB (for sub, 1 = no borrow)
//   ovf    out  signed overflow
//   zf     out  sum == 0
//   sf     out  sum[WIDTH-1]
module seq_chunk_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SEQ_CHUNK_ADDER_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zf,
   output logic             sf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;      // already inverted for subtraction
   logic [WIDTH-1:0] res;      // chunks written so far
   logic             carry;
   logic [IDXW-1:0]  idx;

   logic [CHUNK-1:0] chunk_a;
   logic [CHUNK-1:0] chunk_b;
   logic [CHUNK:0]   partial;
   logic [WIDTH-1:0] res_next;
   logic             last;
   logic             abort_req;

`ifdef SEQ_CHUNK_ADDER_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Signed overflow: both addends share a sign and the result's sign differs.
   function automatic logic ovf_flag(input logic a_msb, input logic b_msb,
                                     input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   // Chunk select, chunk add and insertion into the running result.
   always_comb begin
      chunk_a  = '0;
      chunk_b  = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx == IDXW'(i)) begin
            chunk_a = opa[i*CHUNK +: CHUNK];
            chunk_b = opb[i*CHUNK +: CHUNK];
         end
      end
      partial  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
      res_next = res;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx == IDXW'(i)) begin
            res_next[i*CHUNK +: CHUNK] = partial[CHUNK-1:0];
         end
      end
   end

   assign last = (idx == IDXW'(NCHUNK - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         zf    <= 1'b0;
         sf    <= 1'b0;
         opa   <= '0;
         opb   <= '0;
         res   <= '0;
         carry <= 1'b0;
         idx   <= '0;
      end else begin
         case (state)
            // DONE behaves like IDLE so a start in the done cycle chains
            // straight into the next operation.
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  opa   <= a;
                  opb   <= sub ? ~b : b;
                  carry <= sub;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (abort_req) begin
                  idx   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  res   <= res_next;
                  carry <= partial[CHUNK];
                  idx   <= idx + IDXW'(1);
                  if (last) begin
                     idx   <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     sum   <= res_next;
                     cout  <= partial[CHUNK];
                     ovf   <= ovf_flag(opa[WIDTH-1], opb[WIDTH-1], res_next[WIDTH-1]);
                     zf    <= ~|res_next;
                     sf    <= res_next[WIDTH-1];
                     state <= DONE;
                  end
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder: a 64/8 instance checked every cycle against
// an arithmetic model, plus directed vectors with literal results, and a 16/4
// instance checked with literal results.
module tb_seq_chunk_adder;

   localparam int NCH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start = 1'b0;
   logic        sub   = 1'b0;
   logic [63:0] a     = '0;
   logic [63:0] b     = '0;
   logic        busy, done, cout, ovf, zf, sf;
   logic [63:0] sum;

   logic        start16 = 1'b0;
   logic        sub16   = 1'b0;
   logic [15:0] a16     = '0;
   logic [15:0] b16     = '0;
   logic        busy16, done16, cout16, ovf16, zf16, sf16;
   logic [15:0] sum16;

   logic        abort_s;
`ifdef SEQ_CHUNK_ADDER_ABORT_EN
   logic        abort   = 1'b0;
   logic        abort16 = 1'b0;
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   seq_chunk_adder #(.WIDTH(64), .CHUNK(8)) u64 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
`ifdef SEQ_CHUNK_ADDER_ABORT_EN
      .abort(abort),
`endif
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
      .zf(zf), .sf(sf)
   );

   seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
`ifdef SEQ_CHUNK_ADDER_ABORT_EN
      .abort(abort16),
`endif
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16),
      .zf(zf16), .sf(sf16)
   );

   int n_pass = 0;
   int n_tot  = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference result {sum, cout, ovf, zf, sf} from plain arithmetic.
   function automatic logic [67:0] ref_op(input logic [63:0] x, input logic [63:0] y,
                                          input logic s);
      logic [64:0]        t;
      logic signed [65:0] e;
      logic [63:0]        r;
      logic               c;
      logic               o;
      t = {1'b0, x} + {1'b0, y};
      if (s) begin
         r = x - y;
         c = (x >= y);
         e = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
      end else begin
         r = t[63:0];
         c = t[64];
         e = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
      end
      // The exact signed result fits in 64 bits iff its top three bits agree.
      o = !((e[65:63] == 3'b000) || (e[65:63] == 3'b111));
      return {r, c, o, (r == 64'd0), r[63]};
   endfunction

   // Cycle model: an accepted start publishes its result NCH edges later.
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   int          m_left = 0;
   logic [67:0] m_pend = '0;
   logic [67:0] m_out  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
         m_pend <= '0;
         m_out  <= '0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy <= 1'b1;
               m_left <= NCH;
               m_pend <= ref_op(a, b, sub);
            end
         end else if (abort_s) begin
            m_busy <= 1'b0;
         end else if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_out  <= m_pend;
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en)
         chk("cycle 64", {2'b00, busy, done, sum, cout, ovf, zf, sf},
                         {2'b00, m_busy, m_done, m_out});
   end

   task automatic chk_res(input string nm, input logic [63:0] es, input logic ec,
                          input logic eo, input logic ez, input logic esf);
      chk({nm, " sum"}, 72'(sum), 72'(es));
      chk({nm, " cout/ovf/zf/sf"}, 72'({cout, ovf, zf, sf}), 72'({ec, eo, ez, esf}));
   endtask

   // Called at a negedge; returns at the negedge where done is high.
   task automatic run_op(input logic [63:0] ta, input logic [63:0] tb,
                         input logic ts, output int lat, output int nbusy);
      start = 1'b1; a = ta; b = tb; sub = ts;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      nbusy = 0;
      while (!done && lat < 40) begin
         if (busy) nbusy++;
         @(negedge clk);
         lat++;
      end
   endtask

   int lat, nb, k, ndone;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset outputs 64", 72'({busy, done, sum, cout, ovf, zf, sf}), 72'd0);
      chk("reset outputs 16", 72'({busy16, done16, sum16, cout16, ovf16, zf16, sf16}), 72'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      // 5 + 3
      run_op(64'd5, 64'd3, 1'b0, lat, nb);
      chk("t1 latency", 72'(lat), 72'(8));
      chk("t1 busy cycles", 72'(nb), 72'(8));
      chk_res("t1", 64'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("t1 done single cycle", 72'(done), 72'(0));

      // Positive overflow
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat, nb);
      chk("t2 latency", 72'(lat), 72'(8));
      chk_res("t2", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);

      // 5 - 5 then 0 - 1 started in the done cycle
      run_op(64'd5, 64'd5, 1'b1, lat, nb);
      chk("t3 latency", 72'(lat), 72'(8));
      chk_res("t3", 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      run_op(64'd0, 64'd1, 1'b1, lat, nb);
      chk("t4 back-to-back latency", 72'(lat), 72'(8));
      chk("t4 back-to-back busy cycles", 72'(nb), 72'(8));
      chk_res("t4", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);

      // Start while busy is ignored
      start = 1'b1; a = 64'd10; b = 64'd20; sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      repeat (2) begin @(negedge clk); k++; end
      start = 1'b1; a = 64'd99; b = 64'd0;
      @(negedge clk); k++;
      start = 1'b0;
      chk("t5 busy during ignored start", 72'(busy), 72'(1));
      while (!done && k < 40) begin @(negedge clk); k++; end
      chk("t5 latency", 72'(k), 72'(8));
      chk_res("t5", 64'd30, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      // Reset in the fourth RUN cycle
      start = 1'b1; a = 64'd123; b = 64'd456; sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("t6 outputs cleared by reset", 72'({busy, done, sum, cout, ovf, zf, sf}), 72'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (12) begin @(negedge clk); if (done) ndone++; end
      chk("t6 no done after reset", 72'(ndone), 72'(0));

      // 16-bit instance, 4-bit chunks
      start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0;
      k = 0;
      while (!done16 && k < 40) begin @(negedge clk); k++; end
      chk("t7 latency 16", 72'(k), 72'(4));
      chk("t7 sum 16", 72'(sum16), 72'(16'h0000));
      chk("t7 cout/ovf/zf/sf 16", 72'({cout16, ovf16, zf16, sf16}), 72'(4'b1010));
      @(negedge clk);

`ifdef SEQ_CHUNK_ADDER_ABORT_EN
      run_op(64'd3, 64'd4, 1'b0, lat, nb);
      chk_res("t8 prior", 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1; a = 64'd1; b = 64'd2; sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t8 busy after abort", 72'({busy, done}), 72'(0));
      ndone = 0;
      repeat (10) begin @(negedge clk); if (done) ndone++; end
      chk("t8 no done after abort", 72'(ndone), 72'(0));
      chk_res("t8 held", 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      // abort with start while idle: start wins
      start = 1'b1; abort = 1'b1; a = 64'd2; b = 64'd2; sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("t9 start beats abort", 72'(busy), 72'(1));
      k = 0;
      while (!done && k < 40) begin @(negedge clk); k++; end
      chk_res("t9", 64'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
`endif

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Multi-cycle, parametrised WIDTH-bit adder/subtractor for the y86 ALU path; successor to the single-bit full adder.
- Processes CHUNK bits per clock, LSB chunk first, rippling the carry through a registered carry flop between chunks.
- Start/done handshake. Produces sum plus y86-style condition flags (ZF, SF, OF) and raw carry-out.
- Trades latency for a short combinational path on wide operands.

Parameters:
- WIDTH, 64: operand and result width in bits.
- CHUNK, 8: bits added per cycle. Must divide WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Accepted only when busy=0.
- sub  input  1  0 = a+b, 1 = a-b. Sampled with start.
- a  input  WIDTH  operand A. Sampled with start.
- b  input  WIDTH  operand B. Sampled with start.
- busy  output  1  high while chunks are being processed.
- done  output  1  one-cycle pulse; results valid from this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For sub, 1 = no borrow.
- ovf  output  1  signed overflow.
- zf  output  1  sum == 0.
- sf  output  1  sum[WIDTH-1].

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, sum, cout, ovf, zf, sf all 0. Chunk index=0. Internal operand and carry registers cleared. Takes effect immediately, including mid-RUN; any in-flight operation is discarded and done never pulses for it.
- States: IDLE, RUN, DONE.
  - IDLE/DONE with start=1 at edge E0: latch A=a, B'=(sub ? ~b : b), carry=sub; index=0; go to RUN.
  - RUN: at each edge, partial = A[idx chunk] + B'[idx chunk] + carry. Write the CHUNK-bit result into the internal result register. carry <= chunk carry-out. idx++.
  - RUN, after the edge processing idx=NCHUNK-1: go to DONE.
  - DONE, start=0: return to IDLE.
  - DONE, start=1: immediately start a new op (back-to-back, no idle bubble).
- Latency: done=1 in the cycle following edge E_NCHUNK (NCHUNK edges after the start edge E0). It stays high exactly one cycle unless a new start is accepted.
- busy=1 exactly in RUN state, i.e. NCHUNK cycles per op. busy=0 in IDLE and DONE.
- start while busy=1: ignored, no side effects.
- Output update: sum/cout/ovf/zf/sf update only on the transition into DONE. They hold the previous result throughout RUN and IDLE until the next completion.
- Flags:
  - cout = final carry.
  - ovf = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]).
  - zf = ~|sum.
  - sf = sum[MSB].
- Arithmetic is modulo 2^WIDTH. No saturation.

Optional Feature:
- Macro SEQ_CHUNK_ADDER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 while busy: at the next edge go to IDLE, busy=0, no done pulse. sum/flags keep their prior values.
  - abort in IDLE/DONE: ignored.
  - abort and start in the same cycle while busy=0: start wins.
- Undefined: the abort port does not exist and an operation always runs to completion.

Test Plan:
- WIDTH=64, CHUNK=8: start with a=5, b=3, sub=0 -> busy high 8 cycles; done pulses 8 edges after the start edge; sum=8, cout=0, ovf=0, zf=0, sf=0.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1, sf=1, cout=0, zf=0.
- a=5, b=5, sub=1 -> sum=0, zf=1, cout=1, ovf=0. Then back-to-back a=0, b=1, sub=1 started in the DONE cycle -> sum=0xFFFF_FFFF_FFFF_FFFF, sf=1, cout=0, no idle bubble between ops.
- Start a=10, b=20. Pulse start with a=99 at RUN cycle 3 -> ignored; result sum=30. Then start a new op and drop rst_n at RUN cycle 4 -> all outputs 0 immediately, done never pulses.
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, sub=0 -> done 4 edges after start; sum=0, cout=1, zf=1, ovf=0.
- With SEQ_CHUNK_ADDER_ABORT_EN: a=1, b=2 started, abort at RUN cycle 2 -> busy=0 next cycle, no done; sum/flags keep the previous result.
